// File: rtl/sram_b_15abits_fifo_ctrl.sv
// sram_b_15abits_fifo_ctrl: circular FIFO controller driving a 32768x8 1W/1R SRAM with a 2-entry output buffer
module sram_b_15abits_fifo_ctrl #(
    parameter logic [15:0] AF_THRESH = 16'd32760,
    parameter logic [15:0] AE_THRESH = 16'd8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [7:0]  IN_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [7:0]  OUT_DATA,
    output logic [15:0] COUNT,
    output logic        FULL,
    output logic        EMPTY,
    output logic        ALMOST_FULL,
    output logic        ALMOST_EMPTY,
    output logic        CE0,
    output logic        WE0,
    output logic [14:0] A0,
    output logic [7:0]  D0,
    output logic [7:0]  WEM0,
    output logic        CE1,
    output logic [14:0] A1,
    input  logic [7:0]  Q1
);
    logic [14:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [15:0] mem_cnt_q, mem_cnt_d, count_q, count_d;
    logic        inflight_q, inflight_d;
    logic [1:0]  buf_cnt_q, buf_cnt_d, occ;
    logic [7:0]  buf0_q, buf0_d, buf1_q, buf1_d;
    logic        full_q, full_d, empty_q, empty_d, af_q, af_d, ae_q, ae_d;
    logic        push, pop, rd;

    // Handshakes, SRAM port drive and read issue; occupancy counts a same-cycle pop so reads sustain 1 word/cycle
    always_comb begin
        IN_READY     = !full_q && !RST;
        OUT_VALID    = (buf_cnt_q != 2'd0) && !RST;
        OUT_DATA     = buf0_q;
        push         = IN_VALID && IN_READY;
        pop          = OUT_VALID && OUT_READY;
        occ          = buf_cnt_q - {1'b0, pop} + {1'b0, inflight_q};
        rd           = !RST && (mem_cnt_q != 16'd0) && (occ < 2'd2);
        CE0          = push;
        WE0          = push;
        WEM0         = push ? 8'hFF : 8'h00;
        A0           = push ? wptr_q : 15'd0;
        D0           = push ? IN_DATA : 8'h00;
        CE1          = rd;
        A1           = rd ? rptr_q : 15'd0;
        COUNT        = count_q;
        FULL         = full_q && !RST;
        EMPTY        = empty_q || RST;
        ALMOST_FULL  = af_q && !RST;
        ALMOST_EMPTY = ae_q || RST;
    end

    // Next-state: pointers, counters, output buffer (pop shifts, read data lands behind the remaining entry)
    always_comb begin
        wptr_d     = wptr_q + 15'(push);
        rptr_d     = rptr_q + 15'(rd);
        mem_cnt_d  = mem_cnt_q + 16'(push) - 16'(rd);
        count_d    = count_q + 16'(push) - 16'(pop);
        inflight_d = rd;
        buf0_d     = pop ? buf1_q : buf0_q;
        buf1_d     = buf1_q;
        buf_cnt_d  = buf_cnt_q - {1'b0, pop};
        if (inflight_q) begin
            if (buf_cnt_d == 2'd0) buf0_d = Q1;
            else buf1_d = Q1;
            buf_cnt_d = buf_cnt_d + 2'd1;
        end
        full_d     = count_d == 16'h8000;
        empty_d    = count_d == 16'd0;
        af_d       = count_d >= AF_THRESH;
        ae_d       = count_d <= AE_THRESH;
    end

    // State registers with synchronous reset that also drops any in-flight read
    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr_q     <= 15'd0;
            rptr_q     <= 15'd0;
            mem_cnt_q  <= 16'd0;
            count_q    <= 16'd0;
            inflight_q <= 1'b0;
            buf_cnt_q  <= 2'd0;
            buf0_q     <= 8'h00;
            buf1_q     <= 8'h00;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            mem_cnt_q  <= mem_cnt_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            buf_cnt_q  <= buf_cnt_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
        end
    end
endmodule

// File: tb/tb_sram_b_15abits_fifo_ctrl.sv
// tb_sram_b_15abits_fifo_ctrl: vector table, scoreboard and corner sequences for the SRAM FIFO controller
module tb_sram_b_15abits_fifo_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        ordy = 1'b0;
    logic        in_ready, ov, full, empty, af, ae, ce0, we0, ce1;
    logic [7:0]  out_data, d0, wem0, q1;
    logic [15:0] count;
    logic [14:0] a0, a1;
    logic        t_in_ready, t_ov, t_full, t_empty, t_af, t_ae, t_ce0, t_we0, t_ce1;
    logic [7:0]  t_out_data, t_d0, t_wem0, t_q1;
    logic [15:0] t_count;
    logic [14:0] t_a0, t_a1;
    logic [7:0]  mem [32768];
    logic [7:0]  t_mem [32768];
    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];
    int mcnt = 0;
    logic stall = 1'b0;
    logic [7:0] sdata = 8'h00;

    typedef struct {
        logic        iv;
        logic [7:0]  d;
        logic        ordy;
        logic        ce0;
        logic [14:0] a0;
        logic        ce1;
        logic [14:0] a1;
        logic        ov;
        logic [7:0]  od;
        logic        emp;
        logic [15:0] cnt;
    } vec_t;
    vec_t tbl[13];

    always #5 clk = ~clk;

    sram_b_15abits_fifo_ctrl dut (
        .CLK(clk), .RST(rst), .IN_VALID(iv), .IN_READY(in_ready), .IN_DATA(din),
        .OUT_VALID(ov), .OUT_READY(ordy), .OUT_DATA(out_data), .COUNT(count),
        .FULL(full), .EMPTY(empty), .ALMOST_FULL(af), .ALMOST_EMPTY(ae),
        .CE0(ce0), .WE0(we0), .A0(a0), .D0(d0), .WEM0(wem0),
        .CE1(ce1), .A1(a1), .Q1(q1)
    );

    sram_b_15abits_fifo_ctrl #(.AF_THRESH(16'd4), .AE_THRESH(16'd1)) u_thr (
        .CLK(clk), .RST(rst), .IN_VALID(iv), .IN_READY(t_in_ready), .IN_DATA(din),
        .OUT_VALID(t_ov), .OUT_READY(ordy), .OUT_DATA(t_out_data), .COUNT(t_count),
        .FULL(t_full), .EMPTY(t_empty), .ALMOST_FULL(t_af), .ALMOST_EMPTY(t_ae),
        .CE0(t_ce0), .WE0(t_we0), .A0(t_a0), .D0(t_d0), .WEM0(t_wem0),
        .CE1(t_ce1), .A1(t_a1), .Q1(t_q1)
    );

    // Behavioral SRAMs with registered, 1-cycle read
    always @(posedge clk) begin
        if (ce0 && we0) mem[a0] <= d0;
        if (ce1) q1 <= mem[a1];
        if (t_ce0 && t_we0) t_mem[t_a0] <= t_d0;
        if (t_ce1) t_q1 <= t_mem[t_a1];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        iv = 1'b0;
        ordy = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_ov", 32'(ov), 32'd0);
        chk("rst_ce0", 32'(ce0), 32'd0);
        chk("rst_ce1", 32'(ce1), 32'd0);
        chk("rst_flags", {28'd0, empty, full, ae, af}, 32'b1010);
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard: queue words on accepted push, compare on pop; also track COUNT, IN_READY, CE0, stall stability, A0/A1 conflict
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            mcnt = 0;
            stall = 1'b0;
        end else begin
            chk("count_model", 32'(count), 32'(mcnt));
            chk("in_ready_model", 32'(in_ready), 32'(mcnt != 32768));
            chk("ce0_is_push", 32'(ce0), 32'(iv && in_ready));
            chk("rw_conflict", 32'(ce0 && ce1 && (a0 == a1)), 32'd0);
            if (stall) chk("stall_stable", 32'(out_data), 32'(sdata));
            if (iv && in_ready) q.push_back(din);
            if (ov && ordy) begin
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow got pop expected none at %0t", $time);
                end else chk("sb_data", 32'(out_data), 32'(q.pop_front()));
            end
            mcnt = mcnt + int'(iv && in_ready) - int'(ov && ordy);
            stall = ov && !ordy;
            sdata = out_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 15'd0, 1'b0, 15'd0, 1'b0, 8'h00, 1'b1, 16'd0};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 15'd0, 1'b1, 15'd0, 1'b0, 8'h00, 1'b0, 16'd1};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 15'd0, 1'b0, 15'd0, 1'b0, 8'h00, 1'b0, 16'd1};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 15'd0, 1'b0, 15'd0, 1'b1, 8'hA5, 1'b0, 16'd1};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 15'd0, 1'b0, 15'd0, 1'b0, 8'h00, 1'b1, 16'd0};
        tbl[5]  = '{1'b1, 8'h11, 1'b0, 1'b1, 15'd1, 1'b0, 15'd0, 1'b0, 8'h00, 1'b1, 16'd0};
        tbl[6]  = '{1'b1, 8'h22, 1'b0, 1'b1, 15'd2, 1'b1, 15'd1, 1'b0, 8'h00, 1'b0, 16'd1};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 15'd0, 1'b1, 15'd2, 1'b0, 8'h00, 1'b0, 16'd2};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 15'd0, 1'b0, 15'd0, 1'b1, 8'h11, 1'b0, 16'd2};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 15'd0, 1'b0, 15'd0, 1'b1, 8'h11, 1'b0, 16'd2};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 15'd0, 1'b0, 15'd0, 1'b1, 8'h11, 1'b0, 16'd2};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 15'd0, 1'b0, 15'd0, 1'b1, 8'h22, 1'b0, 16'd1};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 15'd0, 1'b0, 15'd0, 1'b0, 8'h00, 1'b1, 16'd0};
        #1;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            iv = tbl[i].iv;
            din = tbl[i].d;
            ordy = tbl[i].ordy;
            @(negedge clk);
            if (i == 0) chk("ready_after_rst", 32'(in_ready), 32'd1);
            chk($sformatf("row%0d_ce0", i), 32'(ce0), 32'(tbl[i].ce0));
            chk($sformatf("row%0d_a0", i), 32'(a0), 32'(tbl[i].a0));
            chk($sformatf("row%0d_ce1", i), 32'(ce1), 32'(tbl[i].ce1));
            chk($sformatf("row%0d_a1", i), 32'(a1), 32'(tbl[i].a1));
            chk($sformatf("row%0d_ov", i), 32'(ov), 32'(tbl[i].ov));
            if (tbl[i].ov) chk($sformatf("row%0d_od", i), 32'(out_data), 32'(tbl[i].od));
            chk($sformatf("row%0d_empty", i), 32'(empty), 32'(tbl[i].emp));
            chk($sformatf("row%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            tick();
        end

        // Fill to full with the consumer stalled, then pop one with the producer waiting
        do_reset();
        for (int i = 0; i < 32768; i++) begin
            iv = 1'b1;
            din = 8'(i);
            tick();
        end
        din = 8'hEE;
        @(negedge clk);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_count", 32'(count), 32'd32768);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_ce0", 32'(ce0), 32'd0);
        tick();
        ordy = 1'b1;
        din = 8'h77;
        @(negedge clk);
        chk("full_pop_ov", 32'(ov), 32'd1);
        chk("full_pop_in_ready", 32'(in_ready), 32'd0);
        tick();
        ordy = 1'b0;
        @(negedge clk);
        chk("refill_in_ready", 32'(in_ready), 32'd1);
        chk("refill_ce0", 32'(ce0), 32'd1);
        chk("refill_wrap_a0", 32'(a0), 32'd0);
        chk("refill_count", 32'(count), 32'd32767);
        tick();
        iv = 1'b0;
        @(negedge clk);
        chk("refill_full", {16'd0, count}, 32'd32768);
        tick();

        // Continuous traffic with OUT_READY toggling, then drain
        do_reset();
        for (int k = 0; k < 300; k++) begin
            iv = ($urandom_range(3) != 0);
            din = 8'($urandom);
            ordy = (k % 2 == 0);
            tick();
        end
        iv = 1'b0;
        ordy = 1'b1;
        for (int k = 0; k < 400 && count != 16'd0; k++) tick();
        @(negedge clk);
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_sb_empty", 32'(q.size()), 32'd0);
        tick();

        // Reset with COUNT=5 and a read in flight
        do_reset();
        for (int i = 0; i < 6; i++) begin
            iv = 1'b1;
            din = 8'(8'h40 + i);
            tick();
        end
        iv = 1'b0;
        tick();
        ordy = 1'b1;
        @(negedge clk);
        chk("pre_rst_ce1", 32'(ce1), 32'd1);
        tick();
        rst = 1'b1;
        ordy = 1'b0;
        @(negedge clk);
        chk("mid_rst_count5", 32'(count), 32'd5);
        chk("mid_rst_ce0", 32'(ce0), 32'd0);
        chk("mid_rst_ce1", 32'(ce1), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_count", 32'(count), 32'd0);
        chk("post_rst_ov", 32'(ov), 32'd0);
        chk("post_rst_empty", 32'(empty), 32'd1);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        @(negedge clk);
        chk("stale_q1_ov", 32'(ov), 32'd0);
        tick();

        // Threshold flags with AF_THRESH=4, AE_THRESH=1 versus defaults
        do_reset();
        for (int k = 0; k < 6; k++) begin
            iv = 1'b1;
            din = 8'(k);
            @(negedge clk);
            chk($sformatf("thr_ae_k%0d", k), 32'(t_ae), 32'(k <= 1));
            chk($sformatf("thr_af_k%0d", k), 32'(t_af), 32'(k >= 4));
            chk($sformatf("dflt_ae_k%0d", k), 32'(ae), 32'd1);
            chk($sformatf("dflt_af_k%0d", k), 32'(af), 32'd0);
            tick();
        end
        iv = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
